// File: rtl/draw_text_rect.sv
// Text-box overlay: addresses the character and font ROMs for pixels inside a
// fixed box and paints set glyph pixels over a 4-cycle delayed VGA stream.
module draw_text_rect #(
  parameter int          X_POS  = 0,
  parameter int          Y_POS  = 0,
  parameter int          SIZE_X = 4,
  parameter int          SIZE_Y = 4,
  parameter logic [11:0] FG_RGB = 12'hFFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [10:0]               hcount_in,
  input  logic [10:0]               vcount_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      hblnk_in,
  input  logic                      vblnk_in,
  input  logic [11:0]               rgb_in,
  output logic [$clog2(SIZE_X)-1:0] char_x,
  output logic [$clog2(SIZE_Y)-1:0] char_y,
  output logic [3:0]                char_line,
  input  logic [7:0]                char_pixels,
  output logic [10:0]               hcount_out,
  output logic [10:0]               vcount_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      hblnk_out,
  output logic                      vblnk_out,
  output logic [11:0]               rgb_out
);

  localparam int CXW   = $clog2(SIZE_X);
  localparam int CYW   = $clog2(SIZE_Y);
  localparam int X_END = X_POS + 8 * SIZE_X;
  localparam int Y_END = Y_POS + 16 * SIZE_Y;
  localparam int VW    = 38;
  localparam int DEPTH = 4;

  logic [10:0]    dx, dy;
  logic           hit;
  logic [CXW-1:0] char_x_d, char_x_q;
  logic [CYW-1:0] char_y_d, char_y_q;
  logic           in_box1_d, in_box1_q, in_box2_d, in_box2_q, in_box3_d, in_box3_q;
  logic [2:0]     col1_d, col1_q, col2_d, col2_q, col3_d, col3_q;
  logic [3:0]     line1_d, line1_q, char_line_d, char_line_q;
  logic           paint;

  // Box test uses wide integer compares so a box running past 2047 never wraps.
  always_comb begin
    hit = enable
          && (int'(hcount_in) >= X_POS) && (int'(hcount_in) < X_END)
          && (int'(vcount_in) >= Y_POS) && (int'(vcount_in) < Y_END);
    dx = hcount_in - 11'(X_POS);
    dy = vcount_in - 11'(Y_POS);

    char_x_d    = hit ? dx[3 +: CXW] : '0;
    char_y_d    = hit ? dy[4 +: CYW] : '0;
    in_box1_d   = hit;
    col1_d      = hit ? dx[2:0] : 3'd0;
    line1_d     = hit ? dy[3:0] : 4'd0;

    char_line_d = line1_q;
    in_box2_d   = in_box1_q;
    col2_d      = col1_q;
    in_box3_d   = in_box2_q;
    col3_d      = col2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      char_x_q    <= '0;
      char_y_q    <= '0;
      in_box1_q   <= 1'b0;
      col1_q      <= 3'd0;
      line1_q     <= 4'd0;
      char_line_q <= 4'd0;
      in_box2_q   <= 1'b0;
      col2_q      <= 3'd0;
      in_box3_q   <= 1'b0;
      col3_q      <= 3'd0;
    end else begin
      char_x_q    <= char_x_d;
      char_y_q    <= char_y_d;
      in_box1_q   <= in_box1_d;
      col1_q      <= col1_d;
      line1_q     <= line1_d;
      char_line_q <= char_line_d;
      in_box2_q   <= in_box2_d;
      col2_q      <= col2_d;
      in_box3_q   <= in_box3_d;
      col3_q      <= col3_d;
    end
  end

  assign char_x    = char_x_q;
  assign char_y    = char_y_q;
  assign char_line = char_line_q;

  // char_pixels is valid while stage 3 holds the matching in_box/col.
  assign paint = in_box3_q && char_pixels[3'd7 - col3_q];

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_vga
    logic [VW-1:0] vga_d, vga_q;
    if (gi == 0) begin : g_first
      always_comb vga_d = {hcount_in, vcount_in, hsync_in, vsync_in,
                           hblnk_in, vblnk_in, rgb_in};
    end else if (gi == DEPTH - 1) begin : g_last
      // Last stage swaps in the foreground colour; background stays transparent.
      always_comb vga_d = {g_vga[gi-1].vga_q[VW-1:12],
                           paint ? FG_RGB : g_vga[gi-1].vga_q[11:0]};
    end else begin : g_mid
      always_comb vga_d = g_vga[gi-1].vga_q;
    end

    always_ff @(posedge clk) begin
      if (rst) vga_q <= '0;
      else     vga_q <= vga_d;
    end
  end

  assign {hcount_out, vcount_out, hsync_out, vsync_out,
          hblnk_out, vblnk_out, rgb_out} = g_vga[DEPTH-1].vga_q;

endmodule

// File: tb/tb_draw_text_rect.sv
// Randomized scoreboard bench for draw_text_rect with registered char/font ROM models.
module tb_draw_text_rect;

  localparam int          XP  = 100;
  localparam int          YP  = 50;
  localparam int          SX  = 4;
  localparam int          SY  = 4;
  localparam logic [11:0] FG  = 12'hA5C;
  localparam int          CXW = $clog2(SX);
  localparam int          CYW = $clog2(SY);

  logic           clk, rst, enable;
  logic [10:0]    hcount_in, vcount_in;
  logic           hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0]    rgb_in;
  logic [CXW-1:0] char_x;
  logic [CYW-1:0] char_y;
  logic [3:0]     char_line;
  logic [7:0]     char_pixels;
  logic [10:0]    hcount_out, vcount_out;
  logic           hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0]    rgb_out;

  draw_text_rect #(
    .X_POS(XP), .Y_POS(YP), .SIZE_X(SX), .SIZE_Y(SY), .FG_RGB(FG)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .char_x(char_x), .char_y(char_y), .char_line(char_line),
    .char_pixels(char_pixels),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int total = 0;
  int bad   = 0;
  int font_mode = 2;
  bit rst_hist [0:16383];

  function automatic logic [7:0] code_fn(input int cx, input int cy);
    return 8'((cy * SX + cx) * 37 + 5);
  endfunction

  function automatic logic [7:0] glyph_fn(input logic [7:0] code, input int line, input int mode);
    if (mode == 0) return 8'b1000_0001;
    if (mode == 1) return 8'hFF;
    return 8'((int'(code) * 13 + line * 29 + 7) ^ (int'(code) >> 2));
  endfunction

  // External ROMs, each registered with one cycle of latency.
  logic [7:0] code_r;
  always @(posedge clk) begin
    code_r      <= code_fn(int'(char_x), int'(char_y));
    char_pixels <= glyph_fn(code_r, int'(char_line), font_mode);
  end

  typedef struct {
    int          due;
    logic [10:0] h, v;
    logic [3:0]  sy;
    logic [11:0] rgb;
    int          cx, cy, line;
  } exp_t;

  exp_t addr_q[$], line_q[$], out_q[$];

  task automatic drive(input int h, input int v, input bit en, input bit r);
    exp_t e;
    int s, dx, dy;
    bit inb;
    logic [7:0] g;
    @(negedge clk);
    rst = r;
    enable = en;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'($urandom);
    rgb_in = 12'($urandom);
    s = edge_n + 1;
    rst_hist[s] = r;
    inb = en && h >= XP && h < XP + 8 * SX && v >= YP && v < YP + 16 * SY;
    dx = h - XP;
    dy = v - YP;
    e.h = 11'(h);
    e.v = 11'(v);
    e.sy = {hsync_in, vsync_in, hblnk_in, vblnk_in};
    e.cx = inb ? dx / 8 : 0;
    e.cy = inb ? dy / 16 : 0;
    e.line = inb ? dy % 16 : 0;
    e.rgb = rgb_in;
    if (inb) begin
      g = glyph_fn(code_fn(e.cx, e.cy), e.line, font_mode);
      if (g[7 - (dx % 8)]) e.rgb = FG;
    end
    e.due = s;     addr_q.push_back(e);
    e.due = s + 1; line_q.push_back(e);
    e.due = s + 3; out_q.push_back(e);
  endtask

  task automatic flush();
    repeat (6) drive(0, 0, 1'b1, 1'b0);
  endtask

  // Monitor: sample after each edge and retire every expectation due by now.
  initial begin
    exp_t x;
    bit rz;
    forever begin
      @(posedge clk);
      #1;
      while (addr_q.size() > 0 && addr_q[0].due <= edge_n) begin
        x = addr_q.pop_front();
        rz = rst_hist[x.due];
        if (rz) begin x.cx = 0; x.cy = 0; end
        total++;
        if (char_x !== CXW'(x.cx) || char_y !== CYW'(x.cy)) begin
          bad++;
          $display("FAIL addr edge=%0d got x=%0d y=%0d want x=%0d y=%0d",
                   edge_n, char_x, char_y, x.cx, x.cy);
        end
      end
      while (line_q.size() > 0 && line_q[0].due <= edge_n) begin
        x = line_q.pop_front();
        rz = rst_hist[x.due] | rst_hist[x.due-1];
        if (rz) x.line = 0;
        total++;
        if (char_line !== 4'(x.line)) begin
          bad++;
          $display("FAIL char_line edge=%0d got %0d want %0d", edge_n, char_line, x.line);
        end
      end
      while (out_q.size() > 0 && out_q[0].due <= edge_n) begin
        x = out_q.pop_front();
        rz = rst_hist[x.due] | rst_hist[x.due-1] | rst_hist[x.due-2] | rst_hist[x.due-3];
        if (rz) begin x.h = '0; x.v = '0; x.sy = '0; x.rgb = '0; end
        total++;
        if (rgb_out !== x.rgb) begin
          bad++;
          $display("FAIL rgb_out edge=%0d h=%0d v=%0d got %h want %h",
                   edge_n, x.h, x.v, rgb_out, x.rgb);
        end
        total++;
        if (hcount_out !== x.h || vcount_out !== x.v) begin
          bad++;
          $display("FAIL count_out edge=%0d got %0d,%0d want %0d,%0d",
                   edge_n, hcount_out, vcount_out, x.h, x.v);
        end
        total++;
        if ({hsync_out, vsync_out, hblnk_out, vblnk_out} !== x.sy) begin
          bad++;
          $display("FAIL sync_out edge=%0d got %b want %b", edge_n,
                   {hsync_out, vsync_out, hblnk_out, vblnk_out}, x.sy);
        end
      end
    end
  end

  initial begin
    int h, v;
    bit done;
    rst = 1'b1; enable = 1'b0; hcount_in = '0; vcount_in = '0;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    rgb_in = '0; char_pixels = '0; code_r = '0;

    // Reset held with random inputs inside and around the box
    repeat (3) drive($urandom_range(90, 140), $urandom_range(45, 120), 1'b1, 1'b1);

    font_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        h = $urandom_range(0, 2047); v = $urandom_range(0, 2047);
      end else begin
        h = $urandom_range(90, 140); v = $urandom_range(45, 120);
      end
      drive(h, v, $urandom_range(0, 7) != 0, 1'b0);
    end
    drive(117, 83, 1'b1, 1'b0);
    flush();

    // Bit mapping and box edges with the 1000_0001 glyph
    font_mode = 0;
    for (int i = 96; i <= 136; i++) drive(i, 60, 1'b1, 1'b0);
    drive(99, 60, 1'b1, 1'b0);
    drive(131, 60, 1'b1, 1'b0);
    drive(132, 60, 1'b1, 1'b0);
    drive(110, 113, 1'b1, 1'b0);
    drive(110, 114, 1'b1, 1'b0);
    drive(2047, 2047, 1'b1, 1'b0);
    flush();

    // All-ones glyph: enable dropped for 10 pixels, then a one-cycle mid-line reset
    font_mode = 1;
    for (int i = 100; i <= 131; i++) drive(i, 70, !(i >= 110 && i < 120), 1'b0);
    for (int i = 100; i <= 131; i++) drive(i, 71, 1'b1, i == 115);
    flush();

    font_mode = 2;
    for (int i = 0; i < 200; i++)
      drive($urandom_range(95, 137), $urandom_range(45, 118),
            $urandom_range(0, 5) != 0, $urandom_range(0, 49) == 0);
    flush();

    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = (addr_q.size() == 0) && (line_q.size() == 0) && (out_q.size() == 0);
    end
    if (!done) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", addr_q.size() + line_q.size() + out_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
